// File: rtl/hpdcache_id_pool_arbiter.sv
// Shared transaction-identifier pool: round-robin allocation from a circular free-list,
// checked releases, and a drain sequence that waits for every identifier to come back.
module hpdcache_id_pool_arbiter #(
   parameter int unsigned NREQ = 2,
   parameter int unsigned NID  = 8,
   localparam int unsigned ID_W = $clog2(NID),
   localparam int unsigned RR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic [NREQ-1:0] alloc_req_i,
   output logic [NREQ-1:0] alloc_gnt_o,
   output logic [ID_W-1:0] alloc_id_o,
   input  logic            release_i,
   input  logic [ID_W-1:0] release_id_i,
   output logic            release_err_o,
   input  logic            drain_i,
   output logic            drained_o,
   output logic [ID_W:0]   free_cnt_o
);

   typedef enum logic {READY, DRAIN} state_e;

   state_e          state_q, state_d;
   logic [ID_W-1:0] fifo_q [NID];
   logic [ID_W-1:0] rptr_q, wptr_q;
   logic [ID_W:0]   count_q, count_d;
   logic [NID-1:0]  inuse_q, inuse_d;
   logic [RR_W-1:0] rr_q, win, idx;
   logic            found, pop, push, err_q;

   assign alloc_id_o    = fifo_q[rptr_q];
   assign free_cnt_o    = count_q;
   assign release_err_o = err_q;

   // Round-robin search starting at the pointer; the first requester found wins.
   always_comb begin
      alloc_gnt_o = '0;
      win         = '0;
      idx         = '0;
      found       = 1'b0;
      if (state_q == READY && count_q != '0) begin
         for (int i = 0; i < int'(NREQ); i++) begin
            idx = RR_W'((int'(rr_q) + i) % int'(NREQ));
            if (!found && alloc_req_i[idx]) begin
               found = 1'b1;
               win   = idx;
            end
         end
      end
      if (found) alloc_gnt_o[win] = 1'b1;
   end

   // A release only counts when the identifier is currently marked in use.
   always_comb begin
      pop     = found;
      push    = release_i && inuse_q[release_id_i];
      count_d = count_q + (ID_W+1)'(push) - (ID_W+1)'(pop);
      inuse_d = inuse_q;
      if (pop)  inuse_d[alloc_id_o]   = 1'b1;
      if (push) inuse_d[release_id_i] = 1'b0;
   end

   always_comb begin
      state_d   = state_q;
      drained_o = 1'b0;
      case (state_q)
         READY: if (drain_i) state_d = DRAIN;
         DRAIN: begin
            if (count_q == (ID_W+1)'(NID)) begin
               state_d   = READY;
               drained_o = 1'b1;
            end
         end
         default: state_d = READY;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < int'(NID); i++) fifo_q[i] <= ID_W'(i);
         rptr_q  <= '0;
         wptr_q  <= '0;
         count_q <= (ID_W+1)'(NID);
         inuse_q <= '0;
         rr_q    <= '0;
         err_q   <= 1'b0;
         state_q <= READY;
      end else begin
         if (pop) begin
            rptr_q <= rptr_q + 1'b1;
            rr_q   <= (win == RR_W'(NREQ - 1)) ? '0 : win + 1'b1;
         end
         if (push) begin
            fifo_q[wptr_q] <= release_id_i;
            wptr_q         <= wptr_q + 1'b1;
         end
         count_q <= count_d;
         inuse_q <= inuse_d;
         err_q   <= release_i && !inuse_q[release_id_i];
         state_q <= state_d;
      end
   end

   a_gnt_onehot : assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(alloc_gnt_o));
   a_cnt_range  : assert property (@(posedge clk_i) disable iff (rst_i) count_q <= (ID_W+1)'(NID));
   a_bitmap_cnt : assert property (@(posedge clk_i) disable iff (rst_i)
                                   $countones(inuse_q) == int'(NID) - int'(count_q));

endmodule

// File: tb/tb_hpdcache_id_pool_arbiter.sv
// Table-driven bench for hpdcache_id_pool_arbiter: per-cycle vectors of inputs and expected
// outputs, queued as they are driven and compared once the outputs have settled.
module tb_hpdcache_id_pool_arbiter;

   localparam int NREQ = 2;
   localparam int NID  = 8;
   localparam int ID_W = 3;

   logic            clk_i = 1'b0;
   logic            rst_i;
   logic [NREQ-1:0] alloc_req_i;
   logic [NREQ-1:0] alloc_gnt_o;
   logic [ID_W-1:0] alloc_id_o;
   logic            release_i;
   logic [ID_W-1:0] release_id_i;
   logic            release_err_o;
   logic            drain_i;
   logic            drained_o;
   logic [ID_W:0]   free_cnt_o;

   hpdcache_id_pool_arbiter #(.NREQ(NREQ), .NID(NID)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .alloc_req_i(alloc_req_i), .alloc_gnt_o(alloc_gnt_o), .alloc_id_o(alloc_id_o),
      .release_i(release_i), .release_id_i(release_id_i), .release_err_o(release_err_o),
      .drain_i(drain_i), .drained_o(drained_o), .free_cnt_o(free_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      bit              rstb;
      logic [NREQ-1:0] req;
      logic            rel;
      logic [ID_W-1:0] rid;
      logic            drn;
      logic [NREQ-1:0] egnt;
      logic [ID_W-1:0] eid;
      logic [ID_W:0]   ecnt;
      logic            eerr;
      logic            edrn;
      int              tnum;
   } vec_t;

   vec_t vecs[$];
   vec_t sb[$];
   int   testsRun = 0;
   int   testsFailed = 0;
   int   t3ids[6] = '{4, 5, 6, 7, 2, 0};

   function automatic void addv(bit rb, logic [1:0] rq, logic rl, logic [2:0] ri, logic dr,
                                logic [1:0] eg, logic [2:0] ei, logic [3:0] ec, logic ee,
                                logic ed, int tn);
      vec_t v;
      v.rstb = rb; v.req = rq; v.rel = rl; v.rid = ri; v.drn = dr;
      v.egnt = eg; v.eid = ei; v.ecnt = ec; v.eerr = ee; v.edrn = ed; v.tnum = tn;
      vecs.push_back(v);
   endfunction

   task automatic checkField(string name, int tn, int vi, logic [31:0] act, logic [31:0] exp);
      testsRun++;
      if (act !== exp) begin
         testsFailed++;
         $display("[TB] FAIL T%0d vec %0d %s: got %0h, expected %0h", tn, vi, name, act, exp);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      alloc_req_i  = v.req;
      release_i    = v.rel;
      release_id_i = v.rid;
      drain_i      = v.drn;
      sb.push_back(v);
   endtask

   task automatic checkOutput(input int vi);
      vec_t v;
      if (sb.size() == 0) begin
         checkField("scoreboard_empty", 0, vi, 32'd1, 32'd0);
      end else begin
         v = sb.pop_front();
         checkField("alloc_gnt", v.tnum, vi, 32'(alloc_gnt_o), 32'(v.egnt));
         if (v.egnt != '0) checkField("alloc_id", v.tnum, vi, 32'(alloc_id_o), 32'(v.eid));
         checkField("free_cnt", v.tnum, vi, 32'(free_cnt_o), 32'(v.ecnt));
         checkField("release_err", v.tnum, vi, 32'(release_err_o), 32'(v.eerr));
         checkField("drained", v.tnum, vi, 32'(drained_o), 32'(v.edrn));
      end
   endtask

   task automatic doReset();
      @(negedge clk_i);
      alloc_req_i  = '0;
      release_i    = 1'b0;
      release_id_i = '0;
      drain_i      = 1'b0;
      rst_i        = 1'b1;
      #1;
      checkField("rst_free_cnt", 0, -1, 32'(free_cnt_o), 32'(NID));
      checkField("rst_gnt", 0, -1, 32'(alloc_gnt_o), 32'd0);
      checkField("rst_id", 0, -1, 32'(alloc_id_o), 32'd0);
      checkField("rst_err", 0, -1, 32'(release_err_o), 32'd0);
      checkField("rst_drained", 0, -1, 32'(drained_o), 32'd0);
      repeat (2) @(negedge clk_i);
      rst_i = 1'b0;
   endtask

   initial begin
      rst_i        = 1'b1;
      alloc_req_i  = '0;
      release_i    = 1'b0;
      release_id_i = '0;
      drain_i      = 1'b0;

      // T1: single requester drains the whole pool in order
      for (int i = 0; i < 8; i++) addv(i == 0, 2'b01, 0, 0, 0, 2'b01, 3'(i), 4'(8 - i), 0, 0, 1);
      addv(0, 2'b01, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1);
      // T2: two requesters alternate
      for (int i = 0; i < 8; i++)
         addv(i == 0, 2'b11, 0, 0, 0, (i % 2 == 0) ? 2'b01 : 2'b10, 3'(i), 4'(8 - i), 0, 0, 2);
      addv(0, 2'b11, 0, 0, 0, 2'b00, 0, 0, 0, 0, 2);
      // T3: releases go to the tail of the free-list
      for (int i = 0; i < 4; i++) addv(i == 0, 2'b01, 0, 0, 0, 2'b01, 3'(i), 4'(8 - i), 0, 0, 3);
      addv(0, 2'b00, 1, 2, 0, 2'b00, 0, 4, 0, 0, 3);
      addv(0, 2'b00, 1, 0, 0, 2'b00, 0, 5, 0, 0, 3);
      addv(0, 2'b00, 0, 0, 0, 2'b00, 0, 6, 0, 0, 3);
      for (int i = 0; i < 6; i++) addv(0, 2'b01, 0, 0, 0, 2'b01, 3'(t3ids[i]), 4'(6 - i), 0, 0, 3);
      addv(0, 2'b01, 0, 0, 0, 2'b00, 0, 0, 0, 0, 3);
      // T4: spurious release, then release of the id being granted in that cycle
      addv(1, 2'b00, 1, 5, 0, 2'b00, 0, 8, 0, 0, 4);
      addv(0, 2'b00, 0, 0, 0, 2'b00, 0, 8, 1, 0, 4);
      addv(0, 2'b00, 0, 0, 0, 2'b00, 0, 8, 0, 0, 4);
      addv(0, 2'b01, 1, 0, 0, 2'b01, 0, 8, 0, 0, 4);
      addv(0, 2'b00, 0, 0, 0, 2'b00, 0, 7, 1, 0, 4);
      addv(0, 2'b00, 0, 0, 0, 2'b00, 0, 7, 0, 0, 4);
      // T5: empty pool, release and request together: no bypass
      for (int i = 0; i < 8; i++) addv(i == 0, 2'b01, 0, 0, 0, 2'b01, 3'(i), 4'(8 - i), 0, 0, 5);
      addv(0, 2'b01, 1, 3, 0, 2'b00, 0, 0, 0, 0, 5);
      addv(0, 2'b01, 0, 0, 0, 2'b01, 3, 1, 0, 0, 5);
      addv(0, 2'b00, 0, 0, 0, 2'b00, 0, 0, 0, 0, 5);
      // T6: drain with four ids outstanding
      for (int i = 0; i < 4; i++) addv(i == 0, 2'b01, 0, 0, 0, 2'b01, 3'(i), 4'(8 - i), 0, 0, 6);
      addv(0, 2'b00, 0, 0, 1, 2'b00, 0, 4, 0, 0, 6);
      addv(0, 2'b01, 0, 0, 0, 2'b00, 0, 4, 0, 0, 6);
      for (int i = 0; i < 4; i++) addv(0, 2'b01, 1, 3'(i), 0, 2'b00, 0, 4'(4 + i), 0, 0, 6);
      addv(0, 2'b01, 0, 0, 0, 2'b00, 0, 8, 0, 1, 6);
      addv(0, 2'b01, 0, 0, 0, 2'b01, 4, 8, 0, 0, 6);
      // T7: drain on a full pool completes the next cycle
      addv(1, 2'b00, 0, 0, 1, 2'b00, 0, 8, 0, 0, 7);
      addv(0, 2'b01, 0, 0, 0, 2'b00, 0, 8, 0, 1, 7);
      addv(0, 2'b01, 0, 0, 0, 2'b01, 0, 8, 0, 0, 7);

      for (int i = 0; i < vecs.size(); i++) begin
         if (vecs[i].rstb) doReset();
         else @(negedge clk_i);
         applyStimulus(vecs[i]);
         #1;
         checkOutput(i);
      end

      // Reset in the middle of operation restores a full pool
      doReset();
      checkField("sb_leftover", 0, -1, 32'(sb.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
